// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared state encoding and default width for the multiplier
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mult_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_iter_counter.sv
// ============================================================================
// mult_iter_counter : iteration counter for the add/shift sequence
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mult_iter_counter
   import mult_pkg::*;
#(
   parameter  int WIDTH = MULT_WIDTH,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          last
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc)
         count <= count + CW'(1);
   end

   assign last = (count == CW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// mult_seq_ctrl : sequencing FSM producing datapath strobes for the
//                 signed add-shift multiplier
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter  int WIDTH = MULT_WIDTH,
   localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic ClearAX,
   output logic LoadB,
   output logic Add,
   output logic Sub,
   output logic Shift,
   output logic Busy,
   output logic Done
);

   state_t          state;
   state_t          state_next;
   logic            cnt_clr;
   logic            cnt_inc;
   logic [CW-1:0]   count;
   logic            last;

   mult_iter_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk   (Clk),
      .rst   (Reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (count),
      .last  (last)
   );

   always_ff @(posedge Clk) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      ClearAX    = 1'b0;
      LoadB      = 1'b0;
      Add        = 1'b0;
      Sub        = 1'b0;
      Shift      = 1'b0;
      Busy       = 1'b0;
      Done       = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;

      case (state)
         IDLE: begin
            // Load request outranks a start request in the same cycle.
            if (!ClearA_LoadB) begin
               ClearAX = 1'b1;
               LoadB   = 1'b1;
            end else if (!Run) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            ClearAX    = 1'b1;
            Busy       = 1'b1;
            cnt_clr    = 1'b1;
            state_next = ADD;
         end
         ADD: begin
            // The final multiplier bit carries negative weight, so it subtracts.
            Busy       = 1'b1;
            Add        = M & (count != CW'(WIDTH - 1));
            Sub        = M & last;
            state_next = SHIFT;
         end
         SHIFT: begin
            Busy  = 1'b1;
            Shift = 1'b1;
            if (last) begin
               state_next = HOLD;
            end else begin
               cnt_inc    = 1'b1;
               state_next = ADD;
            end
         end
         HOLD: begin
            Done = 1'b1;
            if (Run)
               state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// tb_mult_seq_ctrl : directed self-checking bench with a behavioural datapath
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl;

   logic Clk = 1'b0;
   logic Reset, Run, ClearA_LoadB;
   logic ClearAX, LoadB, Add, Sub, Shift, Busy, Done;
   logic [7:0] S;
   logic [7:0] A, B;
   logic       X;
   logic [8:0] sum_add, sum_sub;
   int         checks = 0;
   int         errors = 0;

   always #5 Clk = ~Clk;

   mult_seq_ctrl #(.WIDTH(8)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .M            (B[0]),
      .ClearAX      (ClearAX),
      .LoadB        (LoadB),
      .Add          (Add),
      .Sub          (Sub),
      .Shift        (Shift),
      .Busy         (Busy),
      .Done         (Done)
   );

   // Behavioural X:A:B datapath driven by the strobes.
   assign sum_add = {A[7], A} + {S[7], S};
   assign sum_sub = {A[7], A} - {S[7], S};

   always @(posedge Clk) begin
      if (ClearAX) begin
         A <= 8'h00;
         X <= 1'b0;
      end
      if (LoadB)
         B <= S;
      if (Add) begin
         A <= sum_add[7:0];
         X <= sum_add[8];
      end
      if (Sub) begin
         A <= sum_sub[7:0];
         X <= sum_sub[8];
      end
      if (Shift) begin
         A <= {X, A[7:1]};
         B <= {A[0], B[7:1]};
      end
   end

   // Output vector order: ClearAX LoadB Add Sub Shift Busy Done
   function automatic logic [6:0] outs();
      return {ClearAX, LoadB, Add, Sub, Shift, Busy, Done};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic load_b(input logic [7:0] bval);
      S            = bval;
      ClearA_LoadB = 1'b0;
      #1;
      chk("load_strobes", 32'(outs()), 32'(7'b1100000));
      tick();
      ClearA_LoadB = 1'b1;
      S            = 8'hC5;
   endtask

   // Press Run and walk the whole operation edge by edge up to HOLD.
   task automatic run_op(input string tag, input logic [7:0] addm, input logic [7:0] subm,
                         input logic [15:0] prod, input int glitch_iter);
      Run = 1'b0;
      tick();
      chk({tag, "_clear"}, 32'(outs()), 32'(7'b1000010));
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == glitch_iter) begin
            ClearA_LoadB = 1'b0;
            #1;
         end
         chk($sformatf("%s_add%0d", tag, i), 32'(outs()),
             32'({2'b00, addm[i], subm[i], 3'b010}));
         tick();
         ClearA_LoadB = 1'b1;
         chk($sformatf("%s_shift%0d", tag, i), 32'(outs()), 32'(7'b0000110));
      end
      tick();
      chk({tag, "_hold"}, 32'(outs()), 32'(7'b0000001));
      chk({tag, "_product"}, 32'({A, B}), 32'(prod));
   endtask

   task automatic release_run(input string tag);
      Run = 1'b1;
      tick();
      chk({tag, "_idle"}, 32'(outs()), 32'(7'b0000000));
   endtask

   initial begin
      int bad;
      Reset        = 1'b1;
      Run          = 1'b1;
      ClearA_LoadB = 1'b1;
      S            = 8'h00;
      tick();
      tick();
      chk("reset_outs", 32'(outs()), 32'(7'b0000000));
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("quiet%0d", i), 32'(outs()), 32'(7'b0000000));
      end

      // 7 x -59
      load_b(8'h07);
      run_op("b07", 8'h07, 8'h00, 16'hFE63, -1);
      release_run("b07");

      // -7 x -59, then hold for 40 cycles with a load request ignored
      load_b(8'hF9);
      run_op("bF9", 8'h79, 8'h80, 16'h019D, -1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         ClearA_LoadB = (i % 3 == 0) ? 1'b0 : 1'b1;
         tick();
         if (outs() !== 7'b0000001) bad++;
      end
      ClearA_LoadB = 1'b0;
      #1;
      chk("hold_ignores_load", 32'(outs()), 32'(7'b0000001));
      chk("hold_40_cycles", 32'(bad), 32'(0));
      ClearA_LoadB = 1'b1;
      Run          = 1'b1;
      tick();
      chk("released_idle", 32'(outs()), 32'(7'b0000000));
      // B now holds 0x9D (-99) from the previous product: -99 x -59 = 5841
      run_op("b9D", 8'h1D, 8'h80, 16'h16D1, -1);
      release_run("b9D");

      // Load and start requested together: load wins, no start
      S            = 8'h07;
      ClearA_LoadB = 1'b0;
      Run          = 1'b0;
      #1;
      chk("both_low_strobes", 32'(outs()), 32'(7'b1100000));
      tick();
      ClearA_LoadB = 1'b1;
      Run          = 1'b1;
      S            = 8'hC5;
      #1;
      chk("both_low_no_start", 32'(outs()), 32'(7'b0000000));
      run_op("glitch", 8'h07, 8'h00, 16'hFE63, 3);
      release_run("glitch");

      // Reset in the middle of an operation (iteration 4 SHIFT)
      load_b(8'hF9);
      Run = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      chk("mid_shift4", 32'(outs()), 32'(7'b0000110));
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      Run   = 1'b1;
      #1;
      chk("mid_reset_outs", 32'(outs()), 32'(7'b0000000));
      tick();
      chk("post_reset_idle", 32'(outs()), 32'(7'b0000000));
      load_b(8'hF9);
      run_op("after_rst", 8'h79, 8'h80, 16'h019D, -1);
      release_run("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencing FSM for the 8-bit signed add-shift multiplier datapath (A:B shift register with sign-extension bit X, adder fed by switches S).
- Converts the Run and ClearA_LoadB button levels into per-cycle datapath strobes: clear, load, add, subtract and shift.
- Counts WIDTH iterations and holds the result until Run is released.
- Sits between the input synchronizers and the datapath inside the multiplier top level.

Parameters:
- WIDTH, 8, operand width and number of add/shift iterations; counter width is $clog2(WIDTH).

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Run  in  1  active-low button level (synchronized upstream); 0 = start request
- ClearA_LoadB  in  1  active-low button level; 0 = clear A/X and load B from S
- M  in  1  current multiplier LSB, B[0], from datapath
- ClearAX  out  1  clear A and X this cycle
- LoadB  out  1  load B from S this cycle
- Add  out  1  A <= A + S, X <= sign of result
- Sub  out  1  A <= A - S, X <= sign of result
- Shift  out  1  arithmetic right shift of X:A:B by one
- Busy  out  1  operation in progress
- Done  out  1  result valid in A:B

Behaviour:
- States (shared enum):
  - IDLE
  - CLEAR
  - ADD
  - SHIFT
  - HOLD
- Reset=1 at an edge, including mid-operation: state IDLE, counter 0. All outputs read 0 from the next cycle. The datapath registers are not touched by this block.
- IDLE:
  - ClearA_LoadB==0: ClearAX=1 and LoadB=1 for every cycle it is held; stay IDLE.
  - Else if Run==0: go to CLEAR.
  - If both are asserted, ClearA_LoadB wins and no start occurs.
- CLEAR: ClearAX=1 for one cycle, counter<=0, go to ADD.
- ADD:
  - Add = M & (count != WIDTH-1).
  - Sub = M & (count == WIDTH-1).
  - Add and Sub are Mealy on M and never both 1.
  - Next state SHIFT.
- SHIFT:
  - Shift=1.
  - If count==WIDTH-1 go to HOLD; else count<=count+1 and go to ADD.
  - Counter wraps to 0 only via CLEAR.
- HOLD:
  - Done=1.
  - Stay while Run==0.
  - When Run==1, go to IDLE.
  - ClearA_LoadB is ignored in HOLD, so one press gives exactly one multiply.
- Busy=1 in CLEAR, ADD and SHIFT.
- ClearA_LoadB and Run are ignored while Busy.
- Latency: the edge sampling Run==0 in IDLE is edge 0.
  - CLEAR at cycle 1.
  - ADD/SHIFT pairs fill cycles 2..2*WIDTH+1.
  - HOLD from cycle 2*WIDTH+2, which is 18 for WIDTH=8.
- Exactly WIDTH Shift pulses per operation.
- At most WIDTH-1 Add pulses and at most one Sub, and the Sub falls only in the final iteration (signed two's-complement multiplier MSB).
- Outputs other than Add/Sub are decoded from registered state only; no output depends combinationally on Run or ClearA_LoadB except IDLE load strobes.

Decomposition:
- Package mult_pkg holds:
  - state typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD}
  - localparam MULT_WIDTH = 8
- One natural sub-module: mult_iter_counter. It is a $clog2(WIDTH)-bit counter with inputs clr and inc, and outputs count and last (count==WIDTH-1).
- The FSM stays in mult_seq_ctrl.

Test Plan:
- Reset and quiet inputs: Reset=1 for 2 cycles with Run=1 and ClearA_LoadB=1 → all outputs 0 and state IDLE; hold 5 cycles, still all 0.
- B=8'b00000111 (bench models the B shift feeding M), Run=0 → Add pulses in iterations 0,1,2, no Sub, 8 Shift pulses. Done rises at cycle 18. With S=8'hC5 (-59), the behavioral datapath gives A:B = 16'hFE63 (-413).
- B=8'hF9 (-7), S=8'hC5, Run=0 → Add in iterations 0,3,4,5,6, Sub in iteration 7; product 16'h019D (+413). Repeat with B=8'h07 and S=8'hC5 → 16'hFE63.
- Run held low for 40 cycles after Done → HOLD persists with no second ClearAX or Shift. Release Run, then press again → new sequence starts; CLEAR appears 2 cycles after the press edge, counting from the release.
- ClearA_LoadB=0 and Run=0 in the same IDLE cycle → LoadB=1, ClearAX=1, no CLEAR state. ClearA_LoadB=0 during ADD at iteration 3 → no LoadB, sequence unchanged.
- Reset=1 at iteration 4 SHIFT → next cycle IDLE with Busy=0 and all strobes 0. A following Run press yields the full 8 iterations with the counter starting at 0.
